pixel_stream_fifo: RTL and testbench

Parametrised pixel buffer for the pixel datapath between producer and consumer sub-blocks.
- Carries PIX_W-bit pixels (default 24, matching the pixel24_t format) plus a start-of-frame tag.
- Uses a valid/ready handshake on both sides.
- Adds depth buffering, fill-level reporting, almost-full indication and synchronous flush, so stages decouple without fixed-latency coupling.

---
 rtl/pixel_stream_fifo.sv | 108 ++++++++++
 tb/tb_pixel_stream_fifo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_fifo.sv
// Pixel FIFO: valid/ready on both sides, first-word-fall-through, fill level, almost-full and flush.
// Define PIXEL_STREAM_FIFO_STATS_EN to enable the frame counter and high-water mark outputs.
module pixel_stream_fifo #(
    parameter int PIX_W = 24,
    parameter int DEPTH = 8,
    parameter int AF_TH = 6,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             cp,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             in_sof,
    output logic             in_ready,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_pixel,
    output logic             out_sof,
    input  logic             out_ready,
    output logic [AW:0]      level,
    output logic             almost_full,
    output logic [15:0]      frame_cnt,
    output logic [AW:0]      max_level
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // in_ready never looks at out_ready, so a full FIFO refuses a push even while popping.

    localparam logic [AW:0] AF_LVL = (AW+1)'(AF_TH);

    logic [PIX_W:0] mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic [AW:0]    wr_nxt;
    logic [AW:0]    rd_nxt;
    logic [AW:0]    level_q;
    logic           rst_state;
    logic           empty;
    logic           full;
    logic           push;
    logic           pop;
    logic [PIX_W:0] head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign in_ready  = !full && !rst_state && !flush;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    assign head      = mem[rd_ptr[AW-1:0]];
    assign out_pixel = empty ? '0 : head[PIX_W-1:0];
    assign out_sof   = empty ? 1'b0 : head[PIX_W];

    // Flush collapses the read side onto the write side; push is already blocked by in_ready.
    assign wr_nxt = wr_ptr + {{AW{1'b0}}, push};
    assign rd_nxt = flush ? wr_ptr : rd_ptr + {{AW{1'b0}}, pop};

    always_ff @(posedge cp or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            rst_state <= 1'b1;
        end else begin
            wr_ptr    <= wr_nxt;
            rd_ptr    <= rd_nxt;
            level_q   <= wr_nxt - rd_nxt;
            rst_state <= 1'b0;
        end
    end

    always_ff @(posedge cp) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {in_sof, in_pixel};
        end
    end

    assign level       = level_q;
    assign almost_full = (level_q >= AF_LVL);

`ifdef PIXEL_STREAM_FIFO_STATS_EN
    logic [15:0] frame_q;
    logic [AW:0] max_q;

    always_ff @(posedge cp or posedge reset) begin
        if (reset) begin
            frame_q <= '0;
            max_q   <= '0;
        end else begin
            if (pop && out_sof) begin
                frame_q <= frame_q + 16'd1;
            end
            if (level_q > max_q) begin
                max_q <= level_q;
            end
        end
    end

    assign frame_cnt = frame_q;
    assign max_level = max_q;
`else
    assign frame_cnt = '0;
    assign max_level = '0;
`endif

endmodule

// File: tb/tb_pixel_stream_fifo.sv
// Bench for pixel_stream_fifo: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of the FIFO.
module tb_pixel_stream_fifo;

    localparam int PIX_W = 24;
    localparam int DEPTH = 8;
    localparam int AF_TH = 6;
    localparam int AW    = 3;

    logic             cp = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic [PIX_W-1:0] in_pixel;
    logic             in_sof;
    logic             in_ready;
    logic             out_valid;
    logic [PIX_W-1:0] out_pixel;
    logic             out_sof;
    logic             out_ready;
    logic [AW:0]      level;
    logic             almost_full;
    logic [15:0]      frame_cnt;
    logic [AW:0]      max_level;

    int vectors    = 0;
    int miscompares = 0;

    pixel_stream_fifo #(.PIX_W(PIX_W), .DEPTH(DEPTH), .AF_TH(AF_TH)) dut (
        .cp(cp), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_pixel(in_pixel), .in_sof(in_sof), .in_ready(in_ready),
        .out_valid(out_valid), .out_pixel(out_pixel), .out_sof(out_sof), .out_ready(out_ready),
        .level(level), .almost_full(almost_full), .frame_cnt(frame_cnt), .max_level(max_level)
    );

    always #5 cp = ~cp;

    // Model: queue of {sof, pixel}, "just left reset" flag, popped-sof count, peak level.
    logic [PIX_W:0] m_q[$];
    logic           m_rs;
    logic [15:0]    m_frames;
    int             m_max;

    always @(posedge cp or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_rs     = 1'b1;
            m_frames = '0;
            m_max    = 0;
        end else begin
            int  sz;
            bit  acc_in;
            bit  acc_out;
            sz      = m_q.size();
            acc_in  = in_valid && (sz < DEPTH) && !m_rs && !flush;
            acc_out = out_ready && (sz > 0) && !flush;
            if (sz > m_max) m_max = sz;
            if (flush) begin
                m_q.delete();
            end else begin
                if (acc_out) begin
                    if (m_q[0][PIX_W]) m_frames = m_frames + 16'd1;
                    void'(m_q.pop_front());
                end
                if (acc_in) m_q.push_back({in_sof, in_pixel});
            end
            m_rs = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int             sz;
        logic [PIX_W:0] hd;
        sz = m_q.size();
        hd = (sz > 0) ? m_q[0] : '0;
        chk("level",       64'(level),       64'(sz));
        chk("out_valid",   64'(out_valid),   64'(sz > 0));
        chk("out_pixel",   64'(out_pixel),   64'(hd[PIX_W-1:0]));
        chk("out_sof",     64'(out_sof),     64'(hd[PIX_W]));
        chk("almost_full", 64'(almost_full), 64'(sz >= AF_TH));
        chk("in_ready",    64'(in_ready),    64'((sz < DEPTH) && !m_rs && !flush));
`ifdef PIXEL_STREAM_FIFO_STATS_EN
        chk("frame_cnt",   64'(frame_cnt),   64'(m_frames));
        chk("max_level",   64'(max_level),   64'(m_max));
`else
        chk("frame_cnt",   64'(frame_cnt),   64'd0);
        chk("max_level",   64'(max_level),   64'd0);
`endif
    endtask

    task automatic tick();
        @(negedge cp);
        check_all();
    endtask

    task automatic drive(input logic v, input logic [PIX_W-1:0] p, input logic s,
                         input logic r, input logic f);
        in_valid  = v;
        in_pixel  = p;
        in_sof    = s;
        out_ready = r;
        flush     = f;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, '0, 0, 0, 0);
        #1 check_all();
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();

        // Fill to full with out_ready low, then try a ninth push.
        for (int i = 1; i <= 8; i++) begin
            drive(1, PIX_W'(i), 0, 0, 0);
            tick();
            if (i == 6) chk("af_at_6", 64'(almost_full), 64'd1);
            if (i == 5) chk("af_at_5", 64'(almost_full), 64'd0);
        end
        chk("full_level", 64'(level), 64'd8);
        chk("full_ready", 64'(in_ready), 64'd0);
        drive(1, 24'h000009, 0, 0, 0);
        tick();
        chk("ninth_level", 64'(level), 64'd8);

        // Drain in order, one per cycle.
        drive(0, '0, 0, 1, 0);
        for (int i = 1; i <= 8; i++) begin
            chk("drain_valid", 64'(out_valid), 64'd1);
            chk("drain_pix", 64'(out_pixel), 64'(i));
            tick();
        end
        chk("empty_valid", 64'(out_valid), 64'd0);
        chk("empty_pix", 64'(out_pixel), 64'd0);

        // Prefill 3, then stream for 20 cycles with push and pop every cycle.
        for (int i = 0; i < 3; i++) begin
            drive(1, PIX_W'($urandom), 1'($urandom_range(0, 1)), 0, 0);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            drive(1, PIX_W'($urandom), 1'($urandom_range(0, 1)), 1, 0);
            tick();
            chk("stream_level", 64'(level), 64'd3);
        end

        // Flush empties; the pixel offered in the flush cycle is dropped.
        drive(0, '0, 0, 0, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, PIX_W'($urandom), 0, 0, 0);
            tick();
        end
        chk("pre_flush_level", 64'(level), 64'd5);
        drive(1, 24'hABCDEF, 1, 0, 1);
        tick();
        chk("flush_level", 64'(level), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        drive(0, '0, 0, 0, 0);
        tick();
        chk("flush_dropped", 64'(level), 64'd0);

        // Random traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), PIX_W'($urandom), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 2) == 0 ? 0 : (i / 100) % 2), 1'($urandom_range(0, 39) == 0));
            tick();
        end

        // Asynchronous reset mid-cycle at level 4.
        drive(0, '0, 0, 0, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, PIX_W'($urandom), 0, 0, 0);
            tick();
        end
        chk("pre_reset_level", 64'(level), 64'd4);
        drive(0, '0, 0, 0, 0);
        #3 reset = 1'b1;
        #1;
        check_all();
        chk("async_level", 64'(level), 64'd0);
        chk("async_valid", 64'(out_valid), 64'd0);
        chk("async_ready", 64'(in_ready), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("release_ready", 64'(in_ready), 64'd0);
        tick();
        chk("after_edge_ready", 64'(in_ready), 64'd1);

`ifdef PIXEL_STREAM_FIFO_STATS_EN
        // Three 4-pixel frames, peak occupancy 6, all popped.
        for (int k = 0; k < 12; k++) begin
            drive(1, PIX_W'(k + 16), (k % 4) == 0, k >= 6, 0);
            tick();
        end
        drive(0, '0, 0, 1, 0);
        for (int k = 0; k < 8; k++) tick();
        chk("frames_3", 64'(frame_cnt), 64'd3);
        chk("max_6", 64'(max_level), 64'd6);

        // Push frame_cnt up to 0xFFFF with sof pops, then wrap.
        drive(1, 24'h000100, 1, 0, 0);
        tick();
        for (int k = 0; k < 65532; k++) begin
            drive(1, PIX_W'(k), 1, 1, 0);
            @(negedge cp);
            if ((k % 4096) == 0) check_all();
        end
        check_all();
        chk("frames_ffff", 64'(frame_cnt), 64'hFFFF);
        drive(0, '0, 0, 1, 0);
        tick();
        chk("frames_wrap", 64'(frame_cnt), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
